time_display_plotter: RTL



---
 rtl/time_display_pkg.sv | 20 ++
 rtl/plot_scan_counter.sv | 58 +++++
 rtl/time_display_plotter.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/time_display_pkg.sv
// Shared constants, state encoding and glyph bit addressing for the time-display plotter.
package time_display_pkg;

    localparam int GLYPH_W    = 5;
    localparam int GLYPH_H    = 8;
    localparam int NUM_CHARS  = 5;
    localparam int GLYPH_BITS = GLYPH_W * GLYPH_H;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_DRAW = 2'd1,
        S_DONE = 2'd2
    } plot_state_t;

    // Row r occupies bits [5r+4:5r]; column 0 is the leftmost pixel.
    function automatic logic [5:0] glyph_bit(input logic [2:0] row, input logic [2:0] col);
        return 6'(int'(row) * GLYPH_W + int'(col));
    endfunction

endpackage

// File: rtl/plot_scan_counter.sv
// Nested char/row/sy/col/sx counter chain walking every magnified glyph pixel in raster order.
module plot_scan_counter
    import time_display_pkg::*;
#(
    parameter int SCALE = 1
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       clear,
    input  logic       advance,
    output logic [2:0] char_idx,
    output logic [2:0] row,
    output logic [1:0] sy,
    output logic [2:0] col,
    output logic [1:0] sx,
    output logic       last
);

    localparam logic [1:0] SUB_MAX  = 2'(SCALE - 1);
    localparam logic [2:0] COL_MAX  = 3'(GLYPH_W - 1);
    localparam logic [2:0] ROW_MAX  = 3'(GLYPH_H - 1);
    localparam logic [2:0] CHAR_MAX = 3'(NUM_CHARS - 1);

    logic sx_end, col_end, sy_end, row_end, char_end;

    assign sx_end   = (sx == SUB_MAX);
    assign col_end  = (col == COL_MAX);
    assign sy_end   = (sy == SUB_MAX);
    assign row_end  = (row == ROW_MAX);
    assign char_end = (char_idx == CHAR_MAX);
    assign last     = sx_end && col_end && sy_end && row_end && char_end;

    // The chain wraps back to all-zero after the final pixel.
    always_ff @(posedge clock) begin
        if (reset || clear) begin
            char_idx <= '0;
            row      <= '0;
            sy       <= '0;
            col      <= '0;
            sx       <= '0;
        end else if (advance) begin
            sx <= sx_end ? '0 : sx + 2'd1;
            if (sx_end) begin
                col <= col_end ? '0 : col + 3'd1;
                if (col_end) begin
                    sy <= sy_end ? '0 : sy + 2'd1;
                    if (sy_end) begin
                        row <= row_end ? '0 : row + 3'd1;
                        if (row_end) begin
                            char_idx <= char_end ? '0 : char_idx + 3'd1;
                        end
                    end
                end
            end
        end
    end

endmodule

// File: rtl/time_display_plotter.sv
// Renders five latched MM:SS glyphs into the framebuffer write port, one pixel per clock.
//   state  | meaning
//   S_IDLE | waiting for start; first pixel is emitted on the accepting edge
//   S_DRAW | emitting remaining pixels; last_q marks that the final pixel is on the port
//   S_DONE | single-cycle completion, start ignored
module time_display_plotter
    import time_display_pkg::*;
#(
    parameter int SCALE      = 1,
    parameter int CHAR_PITCH = 6 * SCALE
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [7:0]  originX,
    input  logic [6:0]  originY,
    input  logic [2:0]  fgColour,
    input  logic [2:0]  bgColour,
    input  logic [39:0] displayMin2,
    input  logic [39:0] displayMin1,
    input  logic [39:0] displayColon,
    input  logic [39:0] displaySec2,
    input  logic [39:0] displaySec1,
    output logic [7:0]  x,
    output logic [6:0]  y,
    output logic [2:0]  colour,
    output logic        plot,
    output logic        busy,
    output logic        done
);

    plot_state_t state, state_d;

    logic [NUM_CHARS-1:0][GLYPH_BITS-1:0] glyphs_in, glyphs_q, glyphs_src;
    logic [7:0] org_x_q, org_x_src;
    logic [6:0] org_y_q, org_y_src;
    logic [2:0] fg_q, bg_q, fg_src, bg_src;

    logic       last_q, last_d;
    logic       latch_en, scan_clear, scan_advance;
    logic [7:0] x_d, px_x;
    logic [6:0] y_d, px_y;
    logic [2:0] colour_d, px_colour;
    logic       plot_d, busy_d, done_d;

    logic [2:0] char_idx, row, col;
    logic [1:0] sy, sx;
    logic       scan_last;

    plot_scan_counter #(.SCALE(SCALE)) u_scan (
        .clock    (clock),
        .reset    (reset),
        .clear    (scan_clear),
        .advance  (scan_advance),
        .char_idx (char_idx),
        .row      (row),
        .sy       (sy),
        .col      (col),
        .sx       (sx),
        .last     (scan_last)
    );

    assign glyphs_in = {displaySec1, displaySec2, displayColon, displayMin1, displayMin2};

    // The accepting edge draws pixel 0 straight from the inputs; later pixels use the latch.
    assign glyphs_src = (state == S_IDLE) ? glyphs_in : glyphs_q;
    assign org_x_src  = (state == S_IDLE) ? originX   : org_x_q;
    assign org_y_src  = (state == S_IDLE) ? originY   : org_y_q;
    assign fg_src     = (state == S_IDLE) ? fgColour  : fg_q;
    assign bg_src     = (state == S_IDLE) ? bgColour  : bg_q;

    assign px_x = org_x_src + 8'(int'(char_idx) * CHAR_PITCH) + 8'(int'(col) * SCALE) + 8'(sx);
    assign px_y = org_y_src + 7'(int'(row) * SCALE) + 7'(sy);
    assign px_colour = glyphs_src[char_idx][glyph_bit(row, col)] ? fg_src : bg_src;

    always_comb begin
        state_d      = state;
        last_d       = last_q;
        x_d          = x;
        y_d          = y;
        colour_d     = colour;
        plot_d       = 1'b0;
        busy_d       = 1'b0;
        done_d       = 1'b0;
        latch_en     = 1'b0;
        scan_clear   = 1'b0;
        scan_advance = 1'b0;
        case (state)
            S_IDLE: begin
                scan_clear = !start;
                if (start) begin
                    latch_en     = 1'b1;
                    scan_advance = 1'b1;
                    x_d          = px_x;
                    y_d          = px_y;
                    colour_d     = px_colour;
                    plot_d       = 1'b1;
                    busy_d       = 1'b1;
                    last_d       = scan_last;
                    state_d      = S_DRAW;
                end
            end
            S_DRAW: begin
                busy_d = 1'b1;
                if (last_q) begin
                    done_d  = 1'b1;
                    last_d  = 1'b0;
                    state_d = S_DONE;
                end else begin
                    scan_advance = 1'b1;
                    x_d          = px_x;
                    y_d          = px_y;
                    colour_d     = px_colour;
                    plot_d       = 1'b1;
                    last_d       = scan_last;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state  <= S_IDLE;
            last_q <= 1'b0;
            x      <= '0;
            y      <= '0;
            colour <= '0;
            plot   <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            state  <= state_d;
            last_q <= last_d;
            x      <= x_d;
            y      <= y_d;
            colour <= colour_d;
            plot   <= plot_d;
            busy   <= busy_d;
            done   <= done_d;
        end
    end

    always_ff @(posedge clock) begin
        if (latch_en) begin
            glyphs_q <= glyphs_in;
            org_x_q  <= originX;
            org_y_q  <= originY;
            fg_q     <= fgColour;
            bg_q     <= bgColour;
        end
    end

endmodule
